// File: rtl/icache_ctrl_if.sv
// Fetch-side and backing-memory signals of the instruction cache, bundled.
// Latency: none (wires only).
// Backpressure: Stall toward the requester, mem_ack from the memory.
// Ports (slave = cache side):
//   Addr, DataIn, Rd, Wr, createdump  requester -> cache
//   DataOut, Done, Stall, CacheHit, err  cache -> requester
//   mem_rd, mem_addr  cache -> memory
//   mem_data, mem_ack  memory -> cache
interface icache_ctrl_if;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic        createdump;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_ack;

  modport slave (
    input  Addr, DataIn, Rd, Wr, createdump, mem_data, mem_ack,
    output DataOut, Done, Stall, CacheHit, err, mem_rd, mem_addr
  );

  modport master (
    output Addr, DataIn, Rd, Wr, createdump, mem_data, mem_ack,
    input  DataOut, Done, Stall, CacheHit, err, mem_rd, mem_addr
  );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache, 4 x 16-bit words per line, flop storage.
// Latency: hit answers in the request cycle; miss answers 5 cycles later with a zero-wait memory.
// Backpressure: Stall held for the whole fill; fill advances one word per mem_ack.
// Ports: clk, rst (async, active-low); bus = icache_ctrl_if.slave
//   (requester Addr/Rd/Wr in, DataOut/Done/Stall/CacheHit/err out; memory mem_rd/mem_addr out,
//   mem_data/mem_ack in).
module icache_ctrl #(
  parameter int INDEX_BITS = 3
) (
  input  logic          clk,
  input  logic          rst,
  icache_ctrl_if.slave  bus
);
  localparam int TAG_BITS = 13 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [15:0]           r_req_addr;
  logic [1:0]            r_cnt;
  logic [LINES-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [15:0]           r_data [LINES][4];

  logic [1:0]            w_offset;
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic [1:0]            w_req_offset;
  logic [INDEX_BITS-1:0] w_req_index;
  logic [TAG_BITS-1:0]   w_req_tag;
  logic                  w_hit;

  logic                  w_latch;
  logic                  w_fill_we;
  logic                  w_fill_last;
  logic [15:0]           w_data_out;
  logic                  w_done;
  logic                  w_stall;
  logic                  w_cache_hit;
  logic                  w_err;
  logic                  w_mem_rd;
  logic [15:0]           w_mem_addr;
  logic                  w_unused;

  assign w_offset     = bus.Addr[2:1];
  assign w_index      = bus.Addr[3 +: INDEX_BITS];
  assign w_tag        = bus.Addr[15:3+INDEX_BITS];
  assign w_req_offset = r_req_addr[2:1];
  assign w_req_index  = r_req_addr[3 +: INDEX_BITS];
  assign w_req_tag    = r_req_addr[15:3+INDEX_BITS];
  assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);

  // Write data and the dump hook have no role in a read-only cache.
  assign w_unused = ^{bus.DataIn, bus.createdump, r_req_addr[0]};

  always_comb begin
    w_next      = r_state;
    w_latch     = 1'b0;
    w_fill_we   = 1'b0;
    w_fill_last = 1'b0;
    w_data_out  = '0;
    w_done      = 1'b0;
    w_stall     = 1'b0;
    w_cache_hit = 1'b0;
    w_err       = 1'b0;
    w_mem_rd    = 1'b0;
    w_mem_addr  = '0;
    case (r_state)
      IDLE: begin
        // Any write, or a misaligned read, is rejected without touching state.
        if (bus.Wr || (bus.Rd && bus.Addr[0])) begin
          w_err = 1'b1;
        end else if (bus.Rd) begin
          if (w_hit) begin
            w_done      = 1'b1;
            w_cache_hit = 1'b1;
            w_data_out  = r_data[w_index][w_offset];
          end else begin
            w_latch = 1'b1;
            w_next  = FILL;
          end
        end
      end
      FILL: begin
        // Requester inputs are ignored here; everything comes from r_req_addr.
        w_stall    = 1'b1;
        w_mem_rd   = 1'b1;
        w_mem_addr = {r_req_addr[15:3], r_cnt, 1'b0};
        if (bus.mem_ack) begin
          w_fill_we = 1'b1;
          if (r_cnt == 2'd3) begin
            w_fill_last = 1'b1;
            w_next      = RESP;
          end
        end
      end
      RESP: begin
        w_done     = 1'b1;
        w_data_out = r_data[w_req_index][w_req_offset];
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, whatever the inputs do.
  assign bus.DataOut  = rst ? w_data_out : '0;
  assign bus.Done     = rst & w_done;
  assign bus.Stall    = rst & w_stall;
  assign bus.CacheHit = rst & w_cache_hit;
  assign bus.err      = rst & w_err;
  assign bus.mem_rd   = rst & w_mem_rd;
  assign bus.mem_addr = rst ? w_mem_addr : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_valid    <= '0;
      r_cnt      <= 2'd0;
      r_req_addr <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_req_addr       <= bus.Addr;
        // The line is about to be overwritten word by word; drop it now.
        r_valid[w_index] <= 1'b0;
      end
      if (w_fill_we) begin
        r_cnt <= r_cnt + 2'd1;  // wraps to 0 on the final word
      end
      if (w_fill_last) begin
        r_valid[w_req_index] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_data[w_req_index][r_cnt] <= bus.mem_data;
    end
    if (w_fill_last) begin
      r_tag[w_req_index] <= w_req_tag;
    end
  end
endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: vector table plus slow-memory and reset-mid-fill sequences.
// Latency: n/a.
// Backpressure: memory model acks every cycle, or every third fill cycle in slow mode.
module tb_icache_ctrl;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic clk;
  logic rst;
  logic slow;
  logic [1:0] wait_cnt;
  logic [15:0] mem [256];
  int checks;
  int errors;

  icache_ctrl_if bus ();

  icache_ctrl #(.INDEX_BITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory: one word per ack, fast or every third fill cycle.
  always_comb begin
    bus.mem_ack  = bus.mem_rd && (!slow || wait_cnt == 2'd2);
    bus.mem_data = bus.mem_ack ? mem[bus.mem_addr[8:1]] : 16'h0000;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) wait_cnt <= 2'd0;
    else if (bus.mem_rd) wait_cnt <= bus.mem_ack ? 2'd0 : wait_cnt + 2'd1;
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic        done;
    logic        hit;
    logic        err;
    logic        stall;
    logic        memrd;
    logic [15:0] data;
    logic [15:0] maddr;
  } vec_t;

  vec_t vecs [25];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [15:0] addr);
    bus.Rd   = rd;
    bus.Wr   = wr;
    bus.Addr = addr;
  endtask

  task automatic chk_idle_zero(input string nm);
    chk1({nm, "_done"}, bus.Done, N);
    chk1({nm, "_stall"}, bus.Stall, N);
    chk1({nm, "_memrd"}, bus.mem_rd, N);
    chk16({nm, "_data"}, bus.DataOut, 16'h0000);
  endtask

  initial begin
    int lat;
    int nack;
    logic found;

    checks = 0;
    errors = 0;
    slow   = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    mem[8]  = 16'h1111;
    mem[9]  = 16'h2222;
    mem[10] = 16'h3333;
    mem[11] = 16'h4444;

    //          rd wr addr      done hit err stall memrd data      maddr
    vecs[0]  = '{Y, N, 16'h0010, N, N, N, N, N, 16'h0000, 16'h0000};
    vecs[1]  = '{Y, N, 16'h0010, N, N, N, Y, Y, 16'h0000, 16'h0010};
    vecs[2]  = '{Y, N, 16'h0010, N, N, N, Y, Y, 16'h0000, 16'h0012};
    vecs[3]  = '{Y, N, 16'h0010, N, N, N, Y, Y, 16'h0000, 16'h0014};
    vecs[4]  = '{Y, N, 16'h0010, N, N, N, Y, Y, 16'h0000, 16'h0016};
    vecs[5]  = '{Y, N, 16'h0010, Y, N, N, N, N, 16'h1111, 16'h0000};
    vecs[6]  = '{Y, N, 16'h0014, Y, Y, N, N, N, 16'h3333, 16'h0000};
    vecs[7]  = '{Y, N, 16'h0021, N, N, Y, N, N, 16'h0000, 16'h0000};
    vecs[8]  = '{N, Y, 16'h0020, N, N, Y, N, N, 16'h0000, 16'h0000};
    vecs[9]  = '{Y, Y, 16'h0010, N, N, Y, N, N, 16'h0000, 16'h0000};
    vecs[10] = '{N, N, 16'h0014, N, N, N, N, N, 16'h0000, 16'h0000};
    vecs[11] = '{Y, N, 16'h0016, Y, Y, N, N, N, 16'h4444, 16'h0000};
    vecs[12] = '{Y, N, 16'h0050, N, N, N, N, N, 16'h0000, 16'h0000};
    vecs[13] = '{Y, N, 16'h0050, N, N, N, Y, Y, 16'h0000, 16'h0050};
    vecs[14] = '{N, Y, 16'h0021, N, N, N, Y, Y, 16'h0000, 16'h0052};
    vecs[15] = '{Y, N, 16'h0010, N, N, N, Y, Y, 16'h0000, 16'h0054};
    vecs[16] = '{Y, N, 16'h0050, N, N, N, Y, Y, 16'h0000, 16'h0056};
    vecs[17] = '{Y, N, 16'h0010, Y, N, N, N, N, 16'hA028, 16'h0000};
    vecs[18] = '{Y, N, 16'h0010, N, N, N, N, N, 16'h0000, 16'h0000};
    vecs[19] = '{Y, N, 16'h0010, N, N, N, Y, Y, 16'h0000, 16'h0010};
    vecs[20] = '{Y, N, 16'h0010, N, N, N, Y, Y, 16'h0000, 16'h0012};
    vecs[21] = '{Y, N, 16'h0010, N, N, N, Y, Y, 16'h0000, 16'h0014};
    vecs[22] = '{Y, N, 16'h0010, N, N, N, Y, Y, 16'h0000, 16'h0016};
    vecs[23] = '{Y, N, 16'h0010, Y, N, N, N, N, 16'h1111, 16'h0000};
    vecs[24] = '{Y, N, 16'h0012, Y, Y, N, N, N, 16'h2222, 16'h0000};

    // Reset with an illegal request applied: every output must stay low.
    rst            = 1'b0;
    bus.DataIn     = 16'h0000;
    bus.createdump = 1'b0;
    drive(Y, Y, 16'h0021);
    #2;
    chk1("rst_err", bus.err, N);
    chk_idle_zero("rst");
    chk16("rst_maddr", bus.mem_addr, 16'h0000);
    chk1("rst_hit", bus.CacheHit, N);
    @(posedge clk); #1;
    drive(N, N, 16'h0000);
    rst = 1'b1;

    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr);
      @(negedge clk);
      chk1($sformatf("v%0d_done", i), bus.Done, vecs[i].done);
      chk1($sformatf("v%0d_hit", i), bus.CacheHit, vecs[i].hit);
      chk1($sformatf("v%0d_err", i), bus.err, vecs[i].err);
      chk1($sformatf("v%0d_stall", i), bus.Stall, vecs[i].stall);
      chk1($sformatf("v%0d_memrd", i), bus.mem_rd, vecs[i].memrd);
      chk16($sformatf("v%0d_data", i), bus.DataOut, vecs[i].data);
      if (vecs[i].memrd)
        chk16($sformatf("v%0d_maddr", i), bus.mem_addr, vecs[i].maddr);
    end

    // Slow memory: ack every third fill cycle, Done 13 cycles after the miss.
    @(posedge clk); #1;
    drive(N, N, 16'h0000);
    @(posedge clk); #1;
    slow = 1'b1;
    drive(Y, N, 16'h0030);
    @(negedge clk);
    chk_idle_zero("slow_miss");
    found = 1'b0;
    lat   = 0;
    nack  = 0;
    for (int k = 1; k <= 40; k++) begin
      if (!found) begin
        @(negedge clk);
        if (bus.Done) begin
          found = 1'b1;
          lat   = k;
        end else if (bus.Stall) begin
          chk16($sformatf("slow_maddr_c%0d", k), bus.mem_addr, 16'h0030 + 16'(2 * nack));
          if (bus.mem_ack) nack++;
        end
      end
    end
    chk1("slow_done_seen", found, Y);
    chk16("slow_latency", 16'(lat), 16'd13);
    chk16("slow_data", bus.DataOut, 16'hA018);
    @(posedge clk); #1;
    slow = 1'b0;
    drive(Y, N, 16'h0036);
    @(negedge clk);
    chk1("slow_rehit", bus.CacheHit, Y);
    chk16("slow_rehit_data", bus.DataOut, 16'hA01B);

    // Reset after two acks abandons the fill; the same address misses again.
    @(posedge clk); #1;
    drive(Y, N, 16'h0040);
    @(negedge clk);
    chk_idle_zero("rmf_miss");
    @(negedge clk);
    chk16("rmf_maddr0", bus.mem_addr, 16'h0040);
    @(negedge clk);
    chk16("rmf_maddr1", bus.mem_addr, 16'h0042);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk1("rmf_rst_stall", bus.Stall, N);
    chk1("rmf_rst_memrd", bus.mem_rd, N);
    chk16("rmf_rst_maddr", bus.mem_addr, 16'h0000);
    chk1("rmf_rst_done", bus.Done, N);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_idle_zero("rmf_remiss");
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      chk1($sformatf("rmf_fill%0d_stall", w), bus.Stall, Y);
      chk16($sformatf("rmf_fill%0d_maddr", w), bus.mem_addr, 16'h0040 + 16'(2 * w));
    end
    @(negedge clk);
    chk1("rmf_resp_done", bus.Done, Y);
    chk16("rmf_resp_data", bus.DataOut, 16'hA020);

    @(posedge clk); #1;
    drive(N, N, 16'h0000);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Responder end of the fetch-to-instruction-cache interface. Accepts read requests on Addr/Rd/Wr and returns DataOut with Done, Stall, CacheHit and err.
- Direct-mapped, read-only instruction cache. Lines are 4 words (8 bytes) of 16-bit words. Tags, valid bits and data are held in flops.
- Misses are filled word by word from a backing memory through a req/ack handshake.
- Sits between the fetch stage (requester) and the instruction memory model.

Parameters:
- INDEX_BITS, 3, number of index bits; the cache has 2^INDEX_BITS lines.
- TAG_BITS, 13 - INDEX_BITS (derived, not overridable), tag width = 16 - 3 - INDEX_BITS.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low.
- Addr  in  16  byte address of requested instruction.
- DataIn  in  16  write data; unused (read-only cache).
- Rd  in  1  read request, level-sensitive.
- Wr  in  1  write request; illegal on this cache.
- createdump  in  1  no functional effect.
- DataOut  out  16  returned instruction; 0 whenever Done=0.
- Done  out  1  request complete this cycle.
- Stall  out  1  cache busy with a fill; requester must hold Addr/Rd.
- CacheHit  out  1  Done was a hit.
- err  out  1  illegal request this cycle.
- mem_rd  out  1  backing-memory read request.
- mem_addr  out  16  backing-memory word address, byte-addressed and even.
- mem_data  in  16  backing-memory read data, valid when mem_ack=1.
- mem_ack  in  1  word accepted and returned this cycle.

Behaviour:
- Address split: Addr[0] must be 0; word offset = Addr[2:1]; index = Addr[3+INDEX_BITS-1:3]; tag = Addr[15:3+INDEX_BITS].
- States: IDLE, FILL, RESP.
- Reset (rst=0, asynchronous):
  - State goes to IDLE and all valid bits clear.
  - All outputs go to 0, including mem_rd and mem_addr.
  - Fill word counter goes to 0. Tag and data arrays need not reset.
  - Reset during FILL abandons the fill; the line stays invalid.
- IDLE, error checks:
  - If Wr=1, or Rd=1 with Addr[0]=1: err=1, Done=0, Stall=0, no state change, no memory access.
  - Rd=0 and Wr=0: all outputs 0.
- IDLE, Rd=1 with legal address:
  - Hit (valid[index] and tag match): combinational same-cycle response. Done=1, CacheHit=1, DataOut = stored word[offset]. State stays IDLE.
  - Miss: latch Addr into req_addr, go to FILL. Done=0 this cycle.
- FILL:
  - Stall=1, Done=0, CacheHit=0.
  - mem_rd=1 with mem_addr = {req_addr[15:3], cnt, 1'b0}, where cnt is a 2-bit counter starting at 0.
  - On mem_ack: write mem_data into data[req_index][cnt], then cnt+1.
  - When the ack arrives with cnt=3: write tag, set valid, clear cnt, go to RESP.
  - mem_rd and mem_addr hold stable until ack. Changes on Addr, Rd or Wr during FILL are ignored.
- RESP (one cycle):
  - Done=1, CacheHit=0, Stall=0.
  - DataOut = data[req_index][req_offset], taken from the latched address, not the live Addr.
  - Next state is IDLE.
- Miss latency: with mem_ack=1 every cycle, Done arrives 5 cycles after the miss cycle.
- A line refill overwrites any previous tag at that index.
- Done, CacheHit and err are mutually exclusive with Stall. err is never 1 together with Done.
- Arithmetic: cnt wraps 3 -> 0 only on the final ack. No other counters exist.

Test Plan:
- Reset then Rd=1, Addr=0x0010, memory returns 0x1111,0x2222,0x3333,0x4444 with ack every cycle:
  - mem_addr runs 0x0010,0x0012,0x0014,0x0016 with Stall=1 for 4 cycles.
  - Then one cycle Done=1, CacheHit=0, DataOut=0x1111.
- Immediately after, Rd=1, Addr=0x0014 -> same-cycle Done=1, CacheHit=1, DataOut=0x3333, mem_rd=0.
- Conflicting line (INDEX_BITS=3):
  - Addr=0x0050 (same index, different tag) -> miss and refill.
  - Then Addr=0x0010 -> miss again with mem_addr starting at 0x0010.
- Error requests:
  - Rd=1, Addr=0x0021 -> err=1, Done=0, Stall=0, mem_rd stays 0.
  - Wr=1, Addr=0x0020 -> err=1.
  - Rd=1, Wr=1 together -> err=1.
- Slow memory: mem_ack asserted only every 3rd cycle during a fill -> mem_addr is held stable between acks, and Done arrives 13 cycles after the miss.
- Reset mid-fill:
  - Assert rst=0 after 2 acks -> outputs 0 immediately.
  - After release, re-request the same Addr -> full 4-word fill restarts at offset 0.
